// File: rtl/loadstore_unit.sv
// Load/store unit: one outstanding memory op. Accept -> ACCESS -> DONE, so the minimum latency is 2 cycles.
// Alignment faults skip the bus, and a stalled bus times out; the unit is busy until DONE returns to IDLE.
module loadstore_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  input  logic                    MemWrite_i,
  input  logic [1:0]              MemType_i,
  input  logic                    MemSign_i,
  input  logic [31:0]             Addr_i,
  input  logic [DATA_WIDTH-1:0]   WriteData_i,
  output logic                    req_ready_o,
  output logic                    Stall_o,
  output logic                    resp_valid_o,
  output logic [DATA_WIDTH-1:0]   ReadData_o,
  output logic                    Misalign_o,
  output logic                    Fault_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [31:0]             mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [3:0]              mem_be_o,
  input  logic                    mem_ack_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [1:0] TYPE_BYTE = 2'b01;
  localparam logic [1:0] TYPE_HALF = 2'b10;
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  type_q, type_d;
  logic        sign_q, sign_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        flt_q, flt_d;

  logic        in_access;
  logic        misaligned;
  logic [3:0]  be;
  logic [31:0] wdata_lanes;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign in_access = (state_q == ACCESS);

  always_comb begin
    misaligned = 1'b0;
    if (MemType_i == TYPE_HALF)      misaligned = Addr_i[0];
    else if (MemType_i != TYPE_BYTE) misaligned = (Addr_i[1:0] != 2'b00);
  end

  always_comb begin
    be          = 4'b1111;
    wdata_lanes = wdata_q;
    if (type_q == TYPE_BYTE) begin
      be          = 4'b0001 << addr_q[1:0];
      wdata_lanes = {4{wdata_q[7:0]}};
    end else if (type_q == TYPE_HALF) begin
      be          = addr_q[1] ? 4'b1100 : 4'b0011;
      wdata_lanes = {2{wdata_q[15:0]}};
    end
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = mem_rdata_i[7:0];
      2'd1:    ld_byte = mem_rdata_i[15:8];
      2'd2:    ld_byte = mem_rdata_i[23:16];
      default: ld_byte = mem_rdata_i[31:24];
    endcase
    ld_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    if (type_q == TYPE_BYTE)
      ld_ext = sign_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
    else if (type_q == TYPE_HALF)
      ld_ext = sign_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
    else
      ld_ext = mem_rdata_i;
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    type_d  = type_q;
    sign_d  = sign_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    flt_d   = flt_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d    = MemWrite_i;
          type_d  = MemType_i;
          sign_d  = MemSign_i;
          addr_d  = Addr_i;
          wdata_d = WriteData_i;
          cnt_d   = 8'd0;
          rdata_d = 32'd0;
          flt_d   = 1'b0;
          mis_d   = misaligned;
          state_d = misaligned ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack_i) begin
          rdata_d = we_q ? 32'd0 : ld_ext;
          state_d = DONE;
        end else if (cnt_q == TMO_LAST) begin
          flt_d   = 1'b1;
          rdata_d = 32'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      type_q  <= 2'b00;
      sign_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      cnt_q   <= 8'd0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      type_q  <= type_d;
      sign_q  <= sign_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      flt_q   <= flt_d;
    end
  end

  // Outputs decode straight from state so an async reset clears them in the same cycle.
  assign req_ready_o  = (state_q == IDLE);
  assign Stall_o      = ((state_q == IDLE) && req_valid_i && !rst_i) || in_access;
  assign resp_valid_o = (state_q == DONE);
  assign ReadData_o   = resp_valid_o ? rdata_q : 32'd0;
  assign Misalign_o   = resp_valid_o && mis_q;
  assign Fault_o      = resp_valid_o && flt_q;

  assign mem_req_o    = in_access;
  assign mem_we_o     = in_access && we_q;
  assign mem_addr_o   = in_access ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_wdata_o  = in_access ? wdata_lanes : 32'd0;
  assign mem_be_o     = in_access ? be : 4'b0000;

endmodule
